bitvec_id_drain: RTL

Downstream of the filter cell, this block converts each result bit vector into a serial stream of set-bit ids. It sits on a `bfpu` output port (`bfpu*_out` / `bfpu*_valid_out`), buffers whole vectors in a small FIFO, and emits the index of every set bit in ascending order under a valid/ready handshake. After each vector it emits a one-cycle done beat carrying the match count. It has no inbound backpressure path into the cell, so a vector that arrives when the FIFO is full is dropped and flagged.

---
 rtl/bitvec_id_drain.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bitvec_id_drain.sv
// Buffers whole result vectors in a small FIFO and drains each one as a stream
// of set-bit ids (ascending), followed by a one-cycle done beat with the id count.
module bitvec_id_drain #(
    parameter int BIT_VEC_SIZE     = 128,
    parameter int BIT_VEC_SIZE_LOG = 7,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BIT_VEC_SIZE-1:0]     vec_in,
    input  logic                        vec_valid_in,
    output logic                        vec_ready,
    output logic [BIT_VEC_SIZE_LOG-1:0] id_out,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic                        id_last,
    output logic                        done_valid,
    output logic [BIT_VEC_SIZE_LOG:0]   done_count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [BIT_VEC_SIZE-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wptr;
    logic [PTR_W-1:0]            r_rptr;
    logic [PTR_W:0]              r_count;
    logic                        r_overflow;
    state_t                      r_state;
    state_t                      w_state_next;
    logic [BIT_VEC_SIZE-1:0]     r_work;
    logic [BIT_VEC_SIZE-1:0]     w_work_next;
    logic [BIT_VEC_SIZE_LOG:0]   r_cnt;
    logic [BIT_VEC_SIZE_LOG:0]   w_cnt_next;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_wr;
    logic                        w_pop;
    logic [BIT_VEC_SIZE-1:0]     w_head;
    logic [BIT_VEC_SIZE-1:0]     w_work_clr;
    logic                        w_is_last;
    logic [BIT_VEC_SIZE_LOG-1:0] w_low_idx;

    // Full/empty come from the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a write.
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr      = vec_valid_in && !w_full;
    assign w_head    = r_mem[r_rptr];
    assign vec_ready = !w_full;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= vec_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (vec_valid_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Lowest set bit wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        w_low_idx = '0;
        for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
            if (r_work[i]) begin
                w_low_idx = BIT_VEC_SIZE_LOG'(i);
            end
        end
    end

    assign w_work_clr = r_work & (r_work - BIT_VEC_SIZE'(1));
    assign w_is_last  = (w_work_clr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        id_valid     = 1'b0;
        id_out       = '0;
        id_last      = 1'b0;
        done_valid   = 1'b0;
        done_count   = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_work_next  = w_head;
                    w_cnt_next   = '0;
                    w_state_next = (w_head != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                id_valid = 1'b1;
                id_out   = w_low_idx;
                id_last  = w_is_last;
                if (id_ready) begin
                    w_work_next = w_work_clr;
                    w_cnt_next  = r_cnt + (BIT_VEC_SIZE_LOG+1)'(1);
                    if (w_is_last) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                done_valid   = 1'b1;
                done_count   = r_cnt;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end
endmodule
